// File: rtl/data_mem_controller.sv
// Data memory access controller for the MEM stage: alignment check, lane steering,
// load extension, LL/SC reservation tracking and a bounded-latency bus timeout.
module data_mem_controller #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        MEM_Read,
    input  logic        MEM_Write,
    input  logic        MEM_Byte,
    input  logic        MEM_Half,
    input  logic        MEM_SignExtend,
    input  logic        MEM_LLSC,
    input  logic [31:0] MEM_Address,
    input  logic [31:0] MEM_WriteData,
    input  logic        IF_Stall,
    input  logic [31:0] DataMem_In,
    input  logic        DataMem_Ready,
    output logic [29:0] DataMem_Address,
    output logic [31:0] DataMem_Out,
    output logic        DataMem_Read,
    output logic [3:0]  DataMem_Write,
    output logic [31:0] MEM_ReadData,
    output logic        MEM_Stall_Controller,
    output logic        MEM_AddrError,
    output logic        MEM_BusError
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_CYCLE = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_llbit;
    logic [29:0]   r_lladdr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_read_data;
    logic          r_bus_error;
    logic          r_dm_read;
    logic [3:0]    r_dm_write;
    logic [29:0]   r_dm_addr;
    logic [31:0]   r_dm_out;
    logic          r_byte;
    logic          r_half;
    logic          r_sext;
    logic          r_ll;
    logic          r_sc;
    logic [1:0]    r_lo;

    logic          w_req;
    logic          w_aligned;
    logic          w_sc;
    logic          w_sc_ok;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_load;
    logic [7:0]    w_lane_b;
    logic [15:0]   w_lane_h;

    assign w_req   = MEM_Read | MEM_Write;
    assign w_sc    = MEM_Write & MEM_LLSC;
    assign w_sc_ok = r_llbit & (r_lladdr == MEM_Address[31:2]);

    // Alignment check and store lane steering from the live MEM-stage request
    always_comb begin
        w_aligned = 1'b0;
        w_be      = 4'b0000;
        w_wdata   = MEM_WriteData;
        if (MEM_Byte) begin
            w_aligned = 1'b1;
            w_be      = 4'b1000 >> MEM_Address[1:0];
            w_wdata   = {4{MEM_WriteData[7:0]}};
        end else if (MEM_Half) begin
            w_aligned = ~MEM_Address[0];
            w_be      = MEM_Address[1] ? 4'b0011 : 4'b1100;
            w_wdata   = {2{MEM_WriteData[15:0]}};
        end else begin
            w_aligned = (MEM_Address[1:0] == 2'b00);
            w_be      = 4'b1111;
            w_wdata   = MEM_WriteData;
        end
    end

    // Load lane extraction (big-endian: byte 0 sits in bits 31:24)
    always_comb begin
        w_lane_b = 8'h00;
        w_lane_h = 16'h0000;
        w_load   = DataMem_In;
        if (r_byte) begin
            case (r_lo)
                2'd0:    w_lane_b = DataMem_In[31:24];
                2'd1:    w_lane_b = DataMem_In[23:16];
                2'd2:    w_lane_b = DataMem_In[15:8];
                default: w_lane_b = DataMem_In[7:0];
            endcase
            w_load = {{24{r_sext & w_lane_b[7]}}, w_lane_b};
        end else if (r_half) begin
            w_lane_h = r_lo[1] ? DataMem_In[15:0] : DataMem_In[31:16];
            w_load   = {{16{r_sext & w_lane_h[15]}}, w_lane_h};
        end else begin
            w_load = DataMem_In;
        end
    end

    // Stall and address error must react within the issuing cycle
    always_comb begin
        MEM_Stall_Controller = 1'b0;
        MEM_AddrError        = 1'b0;
        case (r_state)
            S_IDLE: begin
                MEM_Stall_Controller = w_req & w_aligned;
                MEM_AddrError        = w_req & ~w_aligned;
            end
            S_ACCESS: MEM_Stall_Controller = 1'b1;
            default:  MEM_Stall_Controller = 1'b0;
        endcase
    end

    // Transaction FSM with registered strobes, result and LL reservation
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_llbit     <= 1'b0;
            r_lladdr    <= 30'd0;
            r_count     <= '0;
            r_read_data <= 32'd0;
            r_bus_error <= 1'b0;
            r_dm_read   <= 1'b0;
            r_dm_write  <= 4'b0000;
            r_dm_addr   <= 30'd0;
            r_dm_out    <= 32'd0;
            r_byte      <= 1'b0;
            r_half      <= 1'b0;
            r_sext      <= 1'b0;
            r_ll        <= 1'b0;
            r_sc        <= 1'b0;
            r_lo        <= 2'b00;
        end else begin
            r_bus_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req && w_aligned) begin
                        r_byte <= MEM_Byte;
                        r_half <= MEM_Half;
                        r_sext <= MEM_SignExtend;
                        r_ll   <= MEM_Read & MEM_LLSC;
                        r_sc   <= w_sc;
                        r_lo   <= MEM_Address[1:0];
                        if (w_sc && !w_sc_ok) begin
                            // Failed SC never touches memory
                            r_llbit     <= 1'b0;
                            r_read_data <= 32'd0;
                            r_state     <= S_DONE;
                        end else begin
                            r_dm_read  <= MEM_Read;
                            r_dm_write <= MEM_Write ? w_be : 4'b0000;
                            r_dm_addr  <= MEM_Address[31:2];
                            r_dm_out   <= w_wdata;
                            r_count    <= '0;
                            r_state    <= S_ACCESS;
                            if (w_sc || (MEM_Write && (MEM_Address[31:2] == r_lladdr))) begin
                                r_llbit <= 1'b0;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    if (DataMem_Ready) begin
                        r_dm_read  <= 1'b0;
                        r_dm_write <= 4'b0000;
                        r_state    <= S_DONE;
                        if (r_dm_read) begin
                            r_read_data <= w_load;
                            if (r_ll) begin
                                r_llbit  <= 1'b1;
                                r_lladdr <= r_dm_addr;
                            end
                        end else if (r_sc) begin
                            r_read_data <= 32'd1;
                        end
                    end else if (r_count == LAST_CYCLE) begin
                        r_dm_read   <= 1'b0;
                        r_dm_write  <= 4'b0000;
                        r_bus_error <= 1'b1;
                        r_read_data <= 32'd0;
                        r_state     <= S_DONE;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                S_DONE: begin
                    r_count <= '0;
                    if (!IF_Stall) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign DataMem_Address = r_dm_addr;
    assign DataMem_Out     = r_dm_out;
    assign DataMem_Read    = r_dm_read;
    assign DataMem_Write   = r_dm_write;
    assign MEM_ReadData    = r_read_data;
    assign MEM_BusError    = r_bus_error;

endmodule

// File: tb/tb_data_mem_controller.sv
// Self-checking bench for data_mem_controller: directed scenarios plus randomized
// transactions compared against a transaction-level model.
module tb_data_mem_controller;

    localparam int TMO = 4;

    logic        clock;
    logic        reset_n;
    logic        MEM_Read, MEM_Write, MEM_Byte, MEM_Half, MEM_SignExtend, MEM_LLSC;
    logic [31:0] MEM_Address, MEM_WriteData;
    logic        IF_Stall;
    logic [31:0] DataMem_In;
    logic        DataMem_Ready;
    logic [29:0] DataMem_Address;
    logic [31:0] DataMem_Out;
    logic        DataMem_Read;
    logic [3:0]  DataMem_Write;
    logic [31:0] MEM_ReadData;
    logic        MEM_Stall_Controller, MEM_AddrError, MEM_BusError;

    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference state: LL reservation and last visible result
    bit          ll_valid;
    logic [29:0] ll_word;
    logic [31:0] exp_rd;

    data_mem_controller #(.TIMEOUT(TMO)) dut (
        .clock(clock), .reset_n(reset_n),
        .MEM_Read(MEM_Read), .MEM_Write(MEM_Write), .MEM_Byte(MEM_Byte),
        .MEM_Half(MEM_Half), .MEM_SignExtend(MEM_SignExtend), .MEM_LLSC(MEM_LLSC),
        .MEM_Address(MEM_Address), .MEM_WriteData(MEM_WriteData), .IF_Stall(IF_Stall),
        .DataMem_In(DataMem_In), .DataMem_Ready(DataMem_Ready),
        .DataMem_Address(DataMem_Address), .DataMem_Out(DataMem_Out),
        .DataMem_Read(DataMem_Read), .DataMem_Write(DataMem_Write),
        .MEM_ReadData(MEM_ReadData), .MEM_Stall_Controller(MEM_Stall_Controller),
        .MEM_AddrError(MEM_AddrError), .MEM_BusError(MEM_BusError)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drop_request();
        MEM_Read = 1'b0; MEM_Write = 1'b0; MEM_LLSC = 1'b0;
        DataMem_Ready = 1'b0; IF_Stall = 1'b0;
    endtask

    // One MEM-stage instruction; entered and left just after a rising edge in IDLE.
    // rdy = ACCESS cycle (1-based) in which Ready pulses, 0 = never; ifs = IF_Stall cycles in DONE.
    task automatic txn(input bit rd, input bit wr, input bit by, input bit hf, input bit sx,
                       input bit ls, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rdat, input int rdy, input int ifs);
        bit          aligned, sc, scok, tmo;
        int          len, k, h;
        logic [3:0]  ebe;
        logic [31:0] eout, res;
        logic [29:0] word;
        word = addr[31:2];
        k    = int'(addr[1:0]);
        h    = k / 2;
        aligned = by ? 1'b1 : (hf ? (k % 2 == 0) : (k == 0));
        sc   = wr && ls;
        scok = ll_valid && (ll_word == word);
        if (by) begin
            ebe  = 4'(1 << (3 - k));
            eout = 32'(wd[7:0]) * 32'h0101_0101;
            res  = (rdat >> (8 * (3 - k))) & 32'h0000_00FF;
            if (sx && res[7]) res = res | 32'hFFFF_FF00;
        end else if (hf) begin
            ebe  = (h == 0) ? 4'b1100 : 4'b0011;
            eout = 32'(wd[15:0]) * 32'h0001_0001;
            res  = (rdat >> (16 * (1 - h))) & 32'h0000_FFFF;
            if (sx && res[15]) res = res | 32'hFFFF_0000;
        end else begin
            ebe  = 4'b1111;
            eout = wd;
            res  = rdat;
        end

        MEM_Read = rd; MEM_Write = wr; MEM_Byte = by; MEM_Half = hf;
        MEM_SignExtend = sx; MEM_LLSC = ls; MEM_Address = addr; MEM_WriteData = wd;
        @(negedge clock);
        check_value("addr_err", 32'(MEM_AddrError), 32'(!aligned));
        check_value("issue_stall", 32'(MEM_Stall_Controller), 32'(aligned));
        if (!aligned) begin
            check_value("mis_rd", 32'(DataMem_Read), 32'd0);
            check_value("mis_we", 32'(DataMem_Write), 32'd0);
            @(posedge clock); #1;
            drop_request();
            @(negedge clock);
            check_value("mis_idle_stall", 32'(MEM_Stall_Controller), 32'd0);
            check_value("mis_idle_rd", 32'(DataMem_Read), 32'd0);
            @(posedge clock); #1;
            return;
        end
        @(posedge clock); #1;
        tmo = 1'b0;
        if (sc && !scok) begin
            ll_valid = 1'b0;
            exp_rd   = 32'd0;
        end else begin
            if (sc || (wr && word == ll_word)) ll_valid = 1'b0;
            tmo = !(rdy >= 1 && rdy <= TMO);
            len = tmo ? TMO : rdy;
            MEM_WriteData = $urandom;
            MEM_Address   = $urandom;
            for (int n = 1; n <= len; n++) begin
                DataMem_Ready = (n == rdy);
                DataMem_In    = rdat;
                @(negedge clock);
                check_value("acc_stall", 32'(MEM_Stall_Controller), 32'd1);
                check_value("acc_rd", 32'(DataMem_Read), 32'(rd));
                check_value("acc_we", 32'(DataMem_Write), wr ? 32'(ebe) : 32'd0);
                check_value("acc_addr", 32'(DataMem_Address), 32'(word));
                if (wr) check_value("acc_out", DataMem_Out, eout);
                @(posedge clock); #1;
            end
            DataMem_Ready = 1'b0;
            if (tmo) begin
                exp_rd = 32'd0;
            end else if (rd) begin
                exp_rd = res;
                if (ls) begin
                    ll_valid = 1'b1;
                    ll_word  = word;
                end
            end else if (sc) begin
                exp_rd = 32'd1;
            end
        end
        // DONE: the still-present request and any stray Ready must be ignored
        DataMem_Ready = 1'($urandom_range(0, 1));
        DataMem_In    = $urandom;
        IF_Stall      = (ifs > 0);
        @(negedge clock);
        check_value("done_stall", 32'(MEM_Stall_Controller), 32'd0);
        check_value("done_rd", 32'(DataMem_Read), 32'd0);
        check_value("done_we", 32'(DataMem_Write), 32'd0);
        check_value("rdata", MEM_ReadData, exp_rd);
        check_value("bus_err", 32'(MEM_BusError), 32'(tmo));
        for (int i = 1; i <= ifs; i++) begin
            @(posedge clock); #1;
            DataMem_Ready = 1'b0;
            IF_Stall = (i < ifs);
            @(negedge clock);
            check_value("hold_rdata", MEM_ReadData, exp_rd);
            check_value("hold_stall", 32'(MEM_Stall_Controller), 32'd0);
            check_value("hold_rd", 32'(DataMem_Read), 32'd0);
            check_value("hold_we", 32'(DataMem_Write), 32'd0);
            check_value("hold_berr", 32'(MEM_BusError), 32'd0);
        end
        @(posedge clock); #1;
        drop_request();
    endtask

    initial begin
        bit rd, wr, by, hf, ls;
        int sz;
        logic [31:0] a;
        reset_n = 1'b0;
        MEM_Byte = 1'b0; MEM_Half = 1'b0; MEM_SignExtend = 1'b0;
        MEM_Address = 32'd0; MEM_WriteData = 32'd0; DataMem_In = 32'd0;
        drop_request();
        ll_valid = 1'b0; ll_word = 30'd0; exp_rd = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        check_value("rst_rd", 32'(DataMem_Read), 32'd0);
        check_value("rst_we", 32'(DataMem_Write), 32'd0);
        check_value("rst_rdata", MEM_ReadData, 32'd0);
        check_value("rst_berr", 32'(MEM_BusError), 32'd0);
        check_value("rst_stall", 32'(MEM_Stall_Controller), 32'd0);
        #2 reset_n = 1'b1;
        @(posedge clock); #1;

        // lb sign-extended, Ready in 2nd ACCESS cycle
        txn(1, 0, 1, 0, 1, 0, 32'h0000_0103, 32'd0, 32'h1122_3380, 2, 0);
        // sh to upper address half, then misaligned lh
        txn(0, 1, 0, 1, 0, 0, 32'h0000_0202, 32'h0000_ABCD, 32'd0, 1, 0);
        txn(1, 0, 0, 1, 0, 0, 32'h0000_0201, 32'd0, 32'd0, 1, 0);
        // ll / sc success / sc failure
        txn(1, 0, 0, 0, 0, 1, 32'h0000_0040, 32'd0, 32'hCAFE_F00D, 1, 0);
        txn(0, 1, 0, 0, 0, 1, 32'h0000_0040, 32'h1234_5678, 32'd0, 1, 0);
        txn(0, 1, 0, 0, 0, 1, 32'h0000_0040, 32'h1234_5678, 32'd0, 1, 0);
        // timeout abort, then long IF_Stall hold in DONE
        txn(1, 0, 0, 0, 0, 0, 32'h0000_0080, 32'd0, 32'hDEAD_BEEF, 0, 0);
        txn(1, 0, 0, 0, 0, 0, 32'h0000_0084, 32'd0, 32'h0BAD_F00D, 3, 3);

        // Reset in the middle of an access drops strobes at once and kills the reservation
        txn(1, 0, 0, 0, 0, 1, 32'h0000_0040, 32'd0, 32'h0000_0001, 1, 0);
        MEM_Read = 1'b1; MEM_Byte = 1'b0; MEM_Half = 1'b0; MEM_LLSC = 1'b0;
        MEM_Address = 32'h0000_0088;
        @(posedge clock); #1;
        @(negedge clock);
        check_value("pre_rst_rd", 32'(DataMem_Read), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_value("mid_rst_rd", 32'(DataMem_Read), 32'd0);
        check_value("mid_rst_rdata", MEM_ReadData, 32'd0);
        ll_valid = 1'b0; exp_rd = 32'd0;
        drop_request();
        #1;
        check_value("mid_rst_stall", 32'(MEM_Stall_Controller), 32'd0);
        @(posedge clock);
        #3 reset_n = 1'b1;
        @(posedge clock); #1;
        txn(0, 1, 0, 0, 0, 1, 32'h0000_0040, 32'hFFFF_FFFF, 32'd0, 1, 0);

        for (int t = 0; t < 250; t++) begin
            rd = 1'($urandom_range(0, 1));
            wr = !rd;
            ls = ($urandom_range(0, 3) == 0);
            by = 1'b0; hf = 1'b0;
            if (ls) begin
                a = 32'h0000_0100 + 32'(4 * $urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) a = a + 32'd2;
            end else begin
                sz = $urandom_range(0, 2);
                by = (sz == 0);
                hf = (sz == 1);
                a  = 32'h0000_0100 + 32'($urandom_range(0, 15));
            end
            txn(rd, wr, by, hf, 1'($urandom_range(0, 1)), ls, a, $urandom, $urandom,
                $urandom_range(0, 6), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so a wedged DUT cannot hang the run
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/data_mem_controller.md
DATA_MEM_CONTROLLER -- requirements
Module: data_mem_controller

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum ACCESS cycles before abort.
REQ-002 clock  in  1  single clock; all state changes on rising edge.
REQ-003 reset_n  in  1  reset is asynchronous and active-low.
REQ-004 MEM_Read, MEM_Write  in  1 each  load/store request from MEM stage; never both high.
REQ-005 MEM_Byte, MEM_Half, MEM_SignExtend, MEM_LLSC  in  1 each  size, load extension, LL/SC qualifier.
REQ-006 MEM_Address  in  32  byte address; MEM_WriteData  in  32  store data, already forwarded.
REQ-007 IF_Stall  in  1  external pipeline hold, from instruction fetch.
REQ-008 DataMem_In  in  32  read data; DataMem_Ready  in  1  one-cycle completion strobe.
REQ-009 DataMem_Address  out  30  word address; DataMem_Out  out  32  lane-aligned write data.
REQ-010 DataMem_Read  out  1; DataMem_Write  out  4  byte-enables, bit 3 = byte 0 (big-endian).
REQ-011 MEM_ReadData  out  32  load result, or SC status; MEM_Stall_Controller  out  1  hold the MEM stage.
REQ-012 MEM_AddrError  out  1  misaligned access; MEM_BusError  out  1  timeout abort pulse.

Function
REQ-013 FSM states: IDLE, ACCESS, DONE, encoded in a registered state variable.
REQ-014 IDLE, request (MEM_Read|MEM_Write), aligned -> ACCESS next edge; MEM_Stall_Controller=1 combinationally in that cycle.
REQ-015 Alignment rules: word needs addr[1:0]=00; half needs addr[0]=0; byte is always aligned.
REQ-016 Misaligned request -> MEM_AddrError=1 combinationally in IDLE; no memory strobe; no stall; state stays IDLE.
REQ-017 ACCESS: DataMem_Read or DataMem_Write held constant; DataMem_Address=MEM_Address[31:2]; stall=1.
REQ-018 Strobes are driven from registered copies captured on IDLE->ACCESS, so MEM-stage changes cannot glitch them.
REQ-019 Store byte-enables: word 1111; half addr[1]=0 -> 1100, else 0011; byte 1000>>addr[1:0].
REQ-020 Store data replication: byte to all four lanes; half to both halves.
REQ-021 ACCESS with DataMem_Ready=1 -> DONE next edge; load lane extracted, zero/sign-extended, registered into MEM_ReadData.
REQ-022 ACCESS cycle counter increments each cycle; counter = TIMEOUT with no Ready -> strobes drop, MEM_BusError=1 for one cycle, MEM_ReadData=0, DONE.
REQ-023 DONE: stall=0, MEM_ReadData held; DONE->IDLE when IF_Stall=0; DONE holds while IF_Stall=1.
REQ-024 Requests seen in DONE are the completed instruction and are ignored; no re-issue.
REQ-025 LL (MEM_Read&MEM_LLSC): on completion, set the LLbit register and record address[31:2].
REQ-026 SC (MEM_Write&MEM_LLSC): LLbit=1 and address match -> normal store, MEM_ReadData=1.
REQ-027 SC fail -> no strobe; goes directly to DONE next edge with MEM_ReadData=0.
REQ-028 Any SC clears LLbit; an ordinary store to the recorded word also clears it.
REQ-029 DataMem_Ready outside ACCESS is ignored.

Reset
REQ-030 reset_n low asynchronously forces: state=IDLE, LLbit=0, counter=0, MEM_ReadData=0, all strobes 0, MEM_BusError=0.
REQ-031 Reset mid-ACCESS aborts the transaction; strobes drop immediately with no completion.
REQ-032 Outputs stay at reset values until the first rising edge after reset_n goes high.

Verification
REQ-033 lb, addr 0x103, DataMem_In=0x11223380, SignExtend=1, Ready after 2 cycles -> stall 3 cycles, MEM_ReadData=0xFFFFFF80.
REQ-034 sh, addr 0x202, data 0x0000ABCD -> DataMem_Write=0011, DataMem_Out=0xABCDABCD; lh at 0x201 -> MEM_AddrError=1, no strobe.
REQ-035 ll 0x40 then sc 0x40 -> store issued, result 1; second sc 0x40 -> no strobe, result 0.
REQ-036 Load with Ready never asserted, TIMEOUT=4 -> MEM_BusError pulse after 4 ACCESS cycles, MEM_ReadData=0, stall released.
REQ-037 IF_Stall=1 during DONE for 3 cycles -> MEM_ReadData stable, no new access issued; reset_n low mid-ACCESS -> strobes 0 immediately.
